mult_seq_fsm: RTL and testbench

- Controller that sequences the shared 4-entry register file and ALU datapath to compute an unsigned product A*B.
- Method: repeated addition, ACC = ACC + A, decrementing B until the ALU zero flag fires.
- Sits beside the Fibonacci controller and drives the same datapath control lines: write address/enable, load select, two read addresses and ALU opcode.
- Operands arrive on the datapath's external load bus; the result is left in R2.

---
 rtl/mult_seq_fsm.sv | 129 ++++++++++++
 tb/tb_mult_seq_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_fsm.sv
// Sequencer that drives the shared register file / ALU to form A*B by repeated addition.
// Optional macro MULT_SEQ_FSM_STICKY_DONE_EN: FINISH holds DONE until the next START.
module mult_seq_fsm #(
  parameter int              SIZE    = 4,
  parameter logic [SIZE-2:0] OP_ADD  = 3'b000,
  parameter logic [SIZE-2:0] OP_SUB  = 3'b001,
  parameter logic [SIZE-2:0] OP_ZERO = 3'b010,
  parameter logic [SIZE-2:0] OP_ONE  = 3'b011,
  parameter logic [SIZE-2:0] OP_PASS = 3'b100
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            ZERO_FLAG,
  output logic            wrt_en,
  output logic [SIZE-3:0] wrt_addr,
  output logic            load_data,
  output logic [SIZE-3:0] rd_addr1,
  output logic [SIZE-3:0] rd_addr2,
  output logic [SIZE-2:0] alu_opcode,
  output logic            DONE,
  output logic            BUSY
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD_A  = 4'd1;
  localparam logic [3:0] S_LOAD_B  = 4'd2;
  localparam logic [3:0] S_CLR_ACC = 4'd3;
  localparam logic [3:0] S_SET_ONE = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_ACCUM   = 4'd6;
  localparam logic [3:0] S_DECR    = 4'd7;
  localparam logic [3:0] S_FINISH  = 4'd8;

  // Register map: R0 = A, R1 = B (loop counter), R2 = ACC, R3 = constant 1
  localparam logic [SIZE-3:0] R_A   = 0;
  localparam logic [SIZE-3:0] R_B   = 1;
  localparam logic [SIZE-3:0] R_ACC = 2;
  localparam logic [SIZE-3:0] R_ONE = 3;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // ZERO_FLAG only steers the branches out of CHECK and DECR
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = START ? S_LOAD_A : S_IDLE;
      S_LOAD_A:  w_next = S_LOAD_B;
      S_LOAD_B:  w_next = S_CLR_ACC;
      S_CLR_ACC: w_next = S_SET_ONE;
      S_SET_ONE: w_next = S_CHECK;
      S_CHECK:   w_next = ZERO_FLAG ? S_FINISH : S_ACCUM;
      S_ACCUM:   w_next = S_DECR;
      S_DECR:    w_next = ZERO_FLAG ? S_FINISH : S_ACCUM;
`ifdef MULT_SEQ_FSM_STICKY_DONE_EN
      S_FINISH:  w_next = START ? S_LOAD_A : S_FINISH;
`else
      S_FINISH:  w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wrt_en     = 1'b0;
    wrt_addr   = R_A;
    load_data  = 1'b0;
    rd_addr1   = R_A;
    rd_addr2   = R_A;
    alu_opcode = OP_ADD;
    DONE       = 1'b0;
    BUSY       = (r_state != S_IDLE);
    case (r_state)
      S_LOAD_A: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_addr  = R_A;
      end
      S_LOAD_B: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_addr  = R_B;
      end
      S_CLR_ACC: begin
        wrt_en     = 1'b1;
        wrt_addr   = R_ACC;
        alu_opcode = OP_ZERO;
      end
      S_SET_ONE: begin
        wrt_en     = 1'b1;
        wrt_addr   = R_ONE;
        alu_opcode = OP_ONE;
      end
      S_CHECK: begin
        rd_addr1   = R_B;
        alu_opcode = OP_PASS;
      end
      S_ACCUM: begin
        wrt_en     = 1'b1;
        wrt_addr   = R_ACC;
        rd_addr1   = R_ACC;
        rd_addr2   = R_A;
        alu_opcode = OP_ADD;
      end
      S_DECR: begin
        wrt_en     = 1'b1;
        wrt_addr   = R_B;
        rd_addr1   = R_B;
        rd_addr2   = R_ONE;
        alu_opcode = OP_SUB;
      end
      S_FINISH: begin
        DONE     = 1'b1;
        rd_addr1 = R_ACC;
`ifdef MULT_SEQ_FSM_STICKY_DONE_EN
        BUSY     = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_fsm.sv
// Bench for mult_seq_fsm: behavioural 4x8-bit register file and ALU around the controller.
module tb_mult_seq_fsm;

  localparam int P_IDLE = 0, P_LA = 1, P_LB = 2, P_CLR = 3, P_ONE = 4,
                 P_CHK = 5, P_ACC = 6, P_DEC = 7, P_FIN = 8;
`ifdef MULT_SEQ_FSM_STICKY_DONE_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       CLK, RST, START, ZERO_FLAG;
  logic       wrt_en, load_data, DONE, BUSY;
  logic [1:0] wrt_addr, rd_addr1, rd_addr2;
  logic [2:0] alu_opcode;

  logic [7:0] rf [4];
  logic [7:0] bus, rd1, rd2, alu_res;
  int total = 0;
  int bad   = 0;

  mult_seq_fsm dut (
    .CLK(CLK), .RST(RST), .START(START), .ZERO_FLAG(ZERO_FLAG),
    .wrt_en(wrt_en), .wrt_addr(wrt_addr), .load_data(load_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
    .DONE(DONE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Datapath model
  assign rd1 = rf[rd_addr1];
  assign rd2 = rf[rd_addr2];
  always_comb begin
    alu_res = 8'h00;
    case (alu_opcode)
      3'b000: alu_res = rd1 + rd2;
      3'b001: alu_res = rd1 - rd2;
      3'b010: alu_res = 8'h00;
      3'b011: alu_res = 8'h01;
      3'b100: alu_res = rd1;
      default: alu_res = 8'h00;
    endcase
  end
  assign ZERO_FLAG = (alu_res == 8'h00);
  always @(posedge CLK) if (wrt_en) rf[wrt_addr] <= load_data ? bus : alu_res;

  function automatic logic [12:0] mk(bit we, bit ld, int wa, int r1, int r2, int op,
                                     bit dn, bit by);
    return {we, ld, 2'(wa), 2'(r1), 2'(r2), 3'(op), dn, by};
  endfunction

  // Expected control word for each named step of the algorithm
  function automatic logic [12:0] exp_vec(int ph);
    case (ph)
      P_LA:    return mk(1, 1, 0, 0, 0, 0, 0, 1);
      P_LB:    return mk(1, 1, 1, 0, 0, 0, 0, 1);
      P_CLR:   return mk(1, 0, 2, 0, 0, 2, 0, 1);
      P_ONE:   return mk(1, 0, 3, 0, 0, 3, 0, 1);
      P_CHK:   return mk(0, 0, 0, 1, 0, 4, 0, 1);
      P_ACC:   return mk(1, 0, 2, 2, 0, 0, 0, 1);
      P_DEC:   return mk(1, 0, 1, 1, 3, 1, 0, 1);
      P_FIN:   return mk(0, 0, 0, 2, 0, 0, 1, !STICKY);
      default: return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [12:0] obs_vec();
    return {wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, DONE, BUSY};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One multiplication; abort_at >= 0 pulls RST low during that step index
  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit repulse,
                     input bit hold, input int abort_at);
    int q[$];
    int busy_n;
    logic [7:0] prod;
    busy_n = 0;
    prod = 8'(int'(a) * int'(b));
    q = {P_LA, P_LB, P_CLR, P_ONE, P_CHK};
    for (int i = 0; i < int'(b); i++) begin
      q.push_back(P_ACC);
      q.push_back(P_DEC);
    end
    q.push_back(P_FIN);
    START = 1'b1;
    bus = a;
    tick();
    for (int k = 0; k < q.size(); k++) begin
      if (!hold) START = repulse && (q[k] == P_ACC || q[k] == P_DEC);
      chk($sformatf("step%0d_ph%0d", k, q[k]), 32'(obs_vec()), 32'(exp_vec(q[k])));
      busy_n += int'(BUSY);
      bus = (k == 0) ? a : b;
      if (k == abort_at) begin
        RST = 1'b0;
        START = 1'b0;
        tick();
        chk("abort_reset_vec", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
        RST = 1'b1;
        for (int j = 0; j < 4; j++) begin
          tick();
          chk("abort_no_write", 32'(wrt_en), 32'd0);
          chk("abort_idle_vec", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
        end
        return;
      end
      tick();
    end
    chk("busy_cycles", 32'(busy_n), 32'(6 + 2 * int'(b) - int'(STICKY)));
    chk("R2_product", 32'(rf[2]), 32'(prod));
    chk("R1_counter", 32'(rf[1]), 32'd0);
    if (STICKY) begin
      if (!hold) begin
        for (int j = 0; j < 20; j++) begin
          chk("sticky_done", 32'(obs_vec()), 32'(exp_vec(P_FIN)));
          tick();
        end
      end
    end else begin
      chk("idle_after_finish", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
      if (repulse) begin
        tick();
        chk("no_restart", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    START = 1'b1;
    bus = 8'h00;
    tick();
    chk("reset_with_start", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
    tick();
    chk("reset_hold", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));
    RST = 1'b1;
    START = 1'b0;
    tick();
    chk("idle_no_start", 32'(obs_vec()), 32'(exp_vec(P_IDLE)));

    run(8'd5, 8'd3, 1'b0, 1'b0, -1);
    run(8'd7, 8'd0, 1'b0, 1'b0, -1);
    run(8'd2, 8'd4, 1'b1, 1'b0, -1);
    run(8'd3, 8'd5, 1'b0, 1'b0, 7);
    run(8'd4, 8'd2, 1'b0, 1'b0, -1);
    run(8'd200, 8'd2, 1'b0, 1'b1, -1);
    run(8'd1, 8'd1, 1'b0, 1'b0, -1);
    for (int n = 0; n < 16; n++)
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
